// File: rtl/video_axis_pkg.sv
// Shared definitions for the AXI4-Stream packet arbiter: FSM encoding,
// counter widths and the round-robin successor helper.
package video_axis_pkg;

    // Arbiter FSM: waiting for a request, or forwarding one source's packet.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Width of the completed-packet counter.
    localparam int PKT_COUNT_W = 16;

    // Next index in round-robin order, wrapping back to 0 after num_src-1.
    function automatic int unsigned rr_next(input int unsigned idx,
                                            input int unsigned num_src);
        if (idx + 1 >= num_src) begin
            return 0;
        end
        return idx + 1;
    endfunction

    // Bits needed to index n items; never less than 1 so ports stay legal.
    function automatic int unsigned idx_width(input int unsigned n);
        if (n > 1) begin
            return $clog2(n);
        end
        return 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: picks the first requester after last_grant,
// wrapping modulo NUM_SRC. Purely combinational.
module rr_arbiter
    import video_axis_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int IDX_W   = idx_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_SRC-1:0] grant_onehot,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W-1:0] cand;

    // Walk the sources starting just after last_grant; the first one found wins.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        grant_valid  = 1'b0;
        cand         = last_grant;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = IDX_W'(rr_next(32'(cand), NUM_SRC));
            if (!grant_valid && req[cand]) begin
                grant_valid        = 1'b1;
                grant_idx          = cand;
                grant_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi4stream_packet_arbiter.sv
// Packet-level AXI4-Stream arbiter: locks one source for a whole packet,
// forwards it combinationally, and forces packet end after MAX_BEATS beats.
module axi4stream_packet_arbiter
    import video_axis_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int AXI_WIDTH = 8,
    parameter int MAX_BEATS = 8
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [NUM_SRC*AXI_WIDTH-1:0]      s_tdata,
    input  logic [NUM_SRC-1:0]                s_tvalid,
    input  logic [NUM_SRC-1:0]                s_tlast,
    output logic [NUM_SRC-1:0]                s_tready,
    output logic [AXI_WIDTH-1:0]              m_tdata,
    output logic                              m_tvalid,
    output logic                              m_tlast,
    input  logic                              m_tready,
    output logic [idx_width(NUM_SRC)-1:0]     grant_id,
    output logic                              busy,
    output logic [PKT_COUNT_W-1:0]            pkt_count,
    output logic                              err_overlong
);

    localparam int                IDX_W     = idx_width(NUM_SRC);
    localparam int                BEAT_W    = idx_width(MAX_BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);

    arb_state_e               state_q, state_d;
    logic [IDX_W-1:0]         grant_id_q, grant_id_d;
    logic [NUM_SRC-1:0]       grant_onehot_q, grant_onehot_d;
    logic [IDX_W-1:0]         last_grant_q, last_grant_d;
    logic [BEAT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic [PKT_COUNT_W-1:0]   pkt_count_q, pkt_count_d;
    logic                     err_overlong_q, err_overlong_d;

    logic [NUM_SRC-1:0]       rr_onehot;
    logic [IDX_W-1:0]         rr_idx;
    logic                     rr_valid;

    logic [AXI_WIDTH-1:0]     src_data [NUM_SRC];
    logic                     src_last;
    logic                     beat_fire;

    // Split the flat source bus into one word per source.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign src_data[i] = s_tdata[i*AXI_WIDTH +: AXI_WIDTH];
    end

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req          (s_tvalid),
        .last_grant   (last_grant_q),
        .grant_onehot (rr_onehot),
        .grant_idx    (rr_idx),
        .grant_valid  (rr_valid)
    );

    // Pass-through path: only the granted source reaches the master side.
    always_comb begin
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        s_tready = '0;
        src_last = 1'b0;
        if (state_q == ST_GRANT) begin
            src_last = s_tlast[grant_id_q];
            m_tdata  = src_data[grant_id_q];
            m_tvalid = s_tvalid[grant_id_q];
            m_tlast  = src_last | (beat_cnt_q == LAST_BEAT);
            s_tready = grant_onehot_q & {NUM_SRC{m_tready}};
        end
    end

    assign beat_fire = m_tvalid & m_tready;

    // Next-state logic: arbitrate in IDLE, count beats and close packets in GRANT.
    always_comb begin
        state_d        = state_q;
        grant_id_d     = grant_id_q;
        grant_onehot_d = grant_onehot_q;
        last_grant_d   = last_grant_q;
        beat_cnt_d     = beat_cnt_q;
        pkt_count_d    = pkt_count_q;
        err_overlong_d = err_overlong_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rr_valid) begin
                    state_d        = ST_GRANT;
                    grant_id_d     = rr_idx;
                    grant_onehot_d = rr_onehot;
                    beat_cnt_d     = '0;
                end
            end
            ST_GRANT: begin
                if (beat_fire) begin
                    if (m_tlast) begin
                        state_d      = ST_IDLE;
                        last_grant_d = grant_id_q;
                        beat_cnt_d   = '0;
                        pkt_count_d  = pkt_count_q + 1'b1;
                        if (!src_last) begin
                            err_overlong_d = 1'b1;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers; reset wins over everything and abandons any packet.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q        <= ST_IDLE;
            grant_id_q     <= '0;
            grant_onehot_q <= '0;
            last_grant_q   <= IDX_W'(NUM_SRC - 1);
            beat_cnt_q     <= '0;
            pkt_count_q    <= '0;
            err_overlong_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_id_q     <= grant_id_d;
            grant_onehot_q <= grant_onehot_d;
            last_grant_q   <= last_grant_d;
            beat_cnt_q     <= beat_cnt_d;
            pkt_count_q    <= pkt_count_d;
            err_overlong_q <= err_overlong_d;
        end
    end

    assign grant_id     = grant_id_q;
    assign busy         = (state_q == ST_GRANT);
    assign pkt_count    = pkt_count_q;
    assign err_overlong = err_overlong_q;

endmodule

// File: tb/tb_axi4stream_packet_arbiter.sv
// Directed, table-driven bench for axi4stream_packet_arbiter (2 sources, 8-bit, MAX_BEATS=8).
module tb_axi4stream_packet_arbiter;

    localparam int NUM_SRC   = 2;
    localparam int AXI_WIDTH = 8;
    localparam int MAX_BEATS = 8;

    logic        aclk = 1'b0;
    logic        areset;
    logic [15:0] s_tdata;
    logic [1:0]  s_tvalid;
    logic [1:0]  s_tlast;
    logic [1:0]  s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic [0:0]  grant_id;
    logic        busy;
    logic [15:0] pkt_count;
    logic        err_overlong;

    typedef struct packed {
        logic        rst;
        logic [1:0]  vld;
        logic [1:0]  lst;
        logic [15:0] data;
        logic        mrdy;
    } stim_t;

    typedef struct packed {
        logic        busy;
        logic        gid;
        logic        mv;
        logic        ml;
        logic [7:0]  md;
        logic [1:0]  sr;
        logic [15:0] pc;
        logic        er;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } vec_t;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];
    logic [7:0] pat [4];

    axi4stream_packet_arbiter #(
        .NUM_SRC   (NUM_SRC),
        .AXI_WIDTH (AXI_WIDTH),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tlast      (s_tlast),
        .s_tready     (s_tready),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tlast      (m_tlast),
        .m_tready     (m_tready),
        .grant_id     (grant_id),
        .busy         (busy),
        .pkt_count    (pkt_count),
        .err_overlong (err_overlong)
    );

    // Free-running clock.
    always #5 aclk = ~aclk;

    function automatic stim_t mk_s(input logic rst, input logic [1:0] vld, input logic [1:0] lst,
                                   input logic [15:0] data, input logic mrdy);
        stim_t s;
        s.rst = rst; s.vld = vld; s.lst = lst; s.data = data; s.mrdy = mrdy;
        return s;
    endfunction

    function automatic exp_t mk_e(input logic b, input logic gid, input logic mv, input logic ml,
                                  input logic [7:0] md, input logic [1:0] sr, input logic [15:0] pc,
                                  input logic er);
        exp_t e;
        e.busy = b; e.gid = gid; e.mv = mv; e.ml = ml; e.md = md; e.sr = sr; e.pc = pc; e.er = er;
        return e;
    endfunction

    function automatic vec_t mk_v(input stim_t s, input exp_t e);
        vec_t v;
        v.s = s; v.e = e;
        return v;
    endfunction

    // Drive one cycle of inputs just after the falling edge, then let comb paths settle.
    task automatic applyStimulus(input stim_t s);
        @(negedge aclk);
        areset   = s.rst;
        s_tvalid = s.vld;
        s_tlast  = s.lst;
        s_tdata  = s.data;
        m_tready = s.mrdy;
        #1;
    endtask

    task automatic cmp(input string tag, input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input exp_t e);
        cmp(tag, "busy",         16'(busy),         16'(e.busy));
        cmp(tag, "grant_id",     16'(grant_id),     16'(e.gid));
        cmp(tag, "m_tvalid",     16'(m_tvalid),     16'(e.mv));
        cmp(tag, "m_tlast",      16'(m_tlast),      16'(e.ml));
        cmp(tag, "m_tdata",      16'(m_tdata),      16'(e.md));
        cmp(tag, "s_tready",     16'(s_tready),     16'(e.sr));
        cmp(tag, "pkt_count",    pkt_count,         e.pc);
        cmp(tag, "err_overlong", 16'(err_overlong), 16'(e.er));
    endtask

    task automatic step(input string tag, input stim_t s, input exp_t e);
        applyStimulus(s);
        checkOutput(tag, e);
    endtask

    initial begin
        pat[0] = 8'h21; pat[1] = 8'h43; pat[2] = 8'h65; pat[3] = 8'h87;

        // Reset state, single packet from src0, reset, src0 then src1 with m_tready
        // toggling, a valid gap mid-packet, and a competing request during a packet.
        vecs.push_back(mk_v(mk_s(0, 2'b00, 2'b00, 16'h0000, 1), mk_e(0, 0, 0, 0, 8'h00, 2'b00, 16'd0, 0)));
        vecs.push_back(mk_v(mk_s(0, 2'b01, 2'b00, 16'h00AA, 1), mk_e(0, 0, 0, 0, 8'h00, 2'b00, 16'd0, 0)));
        vecs.push_back(mk_v(mk_s(0, 2'b01, 2'b00, 16'h00AA, 1), mk_e(1, 0, 1, 0, 8'hAA, 2'b01, 16'd0, 0)));
        vecs.push_back(mk_v(mk_s(0, 2'b01, 2'b00, 16'h00BB, 1), mk_e(1, 0, 1, 0, 8'hBB, 2'b01, 16'd0, 0)));
        vecs.push_back(mk_v(mk_s(0, 2'b01, 2'b00, 16'h00CC, 1), mk_e(1, 0, 1, 0, 8'hCC, 2'b01, 16'd0, 0)));
        vecs.push_back(mk_v(mk_s(0, 2'b01, 2'b01, 16'h00DD, 1), mk_e(1, 0, 1, 1, 8'hDD, 2'b01, 16'd0, 0)));
        vecs.push_back(mk_v(mk_s(0, 2'b00, 2'b00, 16'h0000, 1), mk_e(0, 0, 0, 0, 8'h00, 2'b00, 16'd1, 0)));
        vecs.push_back(mk_v(mk_s(1, 2'b00, 2'b00, 16'h0000, 1), mk_e(0, 0, 0, 0, 8'h00, 2'b00, 16'd1, 0)));
        vecs.push_back(mk_v(mk_s(0, 2'b11, 2'b00, 16'hEF11, 1), mk_e(0, 0, 0, 0, 8'h00, 2'b00, 16'd0, 0)));
        vecs.push_back(mk_v(mk_s(0, 2'b11, 2'b00, 16'hEF11, 1), mk_e(1, 0, 1, 0, 8'h11, 2'b01, 16'd0, 0)));
        vecs.push_back(mk_v(mk_s(0, 2'b11, 2'b01, 16'hEF22, 1), mk_e(1, 0, 1, 1, 8'h22, 2'b01, 16'd0, 0)));
        vecs.push_back(mk_v(mk_s(0, 2'b11, 2'b00, 16'hEF33, 1), mk_e(0, 0, 0, 0, 8'h00, 2'b00, 16'd1, 0)));
        vecs.push_back(mk_v(mk_s(0, 2'b11, 2'b00, 16'hEF33, 1), mk_e(1, 1, 1, 0, 8'hEF, 2'b10, 16'd1, 0)));
        vecs.push_back(mk_v(mk_s(0, 2'b11, 2'b00, 16'hBE33, 0), mk_e(1, 1, 1, 0, 8'hBE, 2'b00, 16'd1, 0)));
        vecs.push_back(mk_v(mk_s(0, 2'b11, 2'b00, 16'hBE33, 1), mk_e(1, 1, 1, 0, 8'hBE, 2'b10, 16'd1, 0)));
        vecs.push_back(mk_v(mk_s(0, 2'b11, 2'b00, 16'hAD33, 0), mk_e(1, 1, 1, 0, 8'hAD, 2'b00, 16'd1, 0)));
        vecs.push_back(mk_v(mk_s(0, 2'b11, 2'b00, 16'hAD33, 1), mk_e(1, 1, 1, 0, 8'hAD, 2'b10, 16'd1, 0)));
        vecs.push_back(mk_v(mk_s(0, 2'b11, 2'b10, 16'hDE33, 0), mk_e(1, 1, 1, 1, 8'hDE, 2'b00, 16'd1, 0)));
        vecs.push_back(mk_v(mk_s(0, 2'b11, 2'b10, 16'hDE33, 1), mk_e(1, 1, 1, 1, 8'hDE, 2'b10, 16'd1, 0)));
        vecs.push_back(mk_v(mk_s(0, 2'b00, 2'b00, 16'h0000, 1), mk_e(0, 1, 0, 0, 8'h00, 2'b00, 16'd2, 0)));
        vecs.push_back(mk_v(mk_s(0, 2'b01, 2'b00, 16'h0055, 1), mk_e(0, 1, 0, 0, 8'h00, 2'b00, 16'd2, 0)));
        vecs.push_back(mk_v(mk_s(0, 2'b01, 2'b00, 16'h0055, 1), mk_e(1, 0, 1, 0, 8'h55, 2'b01, 16'd2, 0)));
        vecs.push_back(mk_v(mk_s(0, 2'b00, 2'b00, 16'h0066, 1), mk_e(1, 0, 0, 0, 8'h66, 2'b01, 16'd2, 0)));
        vecs.push_back(mk_v(mk_s(0, 2'b00, 2'b00, 16'h0066, 1), mk_e(1, 0, 0, 0, 8'h66, 2'b01, 16'd2, 0)));
        vecs.push_back(mk_v(mk_s(0, 2'b11, 2'b01, 16'h7766, 1), mk_e(1, 0, 1, 1, 8'h66, 2'b01, 16'd2, 0)));
        vecs.push_back(mk_v(mk_s(0, 2'b10, 2'b00, 16'h7700, 1), mk_e(0, 0, 0, 0, 8'h00, 2'b00, 16'd3, 0)));
        vecs.push_back(mk_v(mk_s(0, 2'b10, 2'b10, 16'h7700, 1), mk_e(1, 1, 1, 1, 8'h77, 2'b10, 16'd3, 0)));
        vecs.push_back(mk_v(mk_s(0, 2'b00, 2'b00, 16'h0000, 1), mk_e(0, 1, 0, 0, 8'h00, 2'b00, 16'd4, 0)));

        areset = 1'b1; s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1;
        applyStimulus(mk_s(1, 2'b00, 2'b00, 16'h0000, 1));
        applyStimulus(mk_s(1, 2'b00, 2'b00, 16'h0000, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].s, vecs[i].e);
        end

        // Overlong packet: src0 never asserts tlast, so beat 8 is forced last.
        step("ovl_idle", mk_s(0, 2'b01, 2'b00, {8'h00, pat[0]}, 1),
             mk_e(0, 1, 0, 0, 8'h00, 2'b00, 16'd4, 0));
        for (int b = 0; b < MAX_BEATS; b++) begin
            step($sformatf("ovl_beat%0d", b), mk_s(0, 2'b01, 2'b00, {8'h00, pat[2'(b)]}, 1),
                 mk_e(1, 0, 1, (b == MAX_BEATS - 1), pat[2'(b)], 2'b01, 16'd4, 0));
        end
        step("ovl_gap",   mk_s(0, 2'b01, 2'b00, {8'h00, pat[0]}, 1),
             mk_e(0, 0, 0, 0, 8'h00, 2'b00, 16'd5, 1));
        step("ovl_rest0", mk_s(0, 2'b01, 2'b00, {8'h00, pat[0]}, 1),
             mk_e(1, 0, 1, 0, pat[0], 2'b01, 16'd5, 1));
        step("ovl_rest1", mk_s(0, 2'b01, 2'b01, {8'h00, pat[1]}, 1),
             mk_e(1, 0, 1, 1, pat[1], 2'b01, 16'd5, 1));
        step("ovl_done",  mk_s(0, 2'b00, 2'b00, 16'h0000, 1),
             mk_e(0, 0, 0, 0, 8'h00, 2'b00, 16'd6, 1));

        // Reset in the middle of a src0 packet, then src1 alone is served.
        step("rst_req",   mk_s(0, 2'b01, 2'b00, 16'h0090, 1), mk_e(0, 0, 0, 0, 8'h00, 2'b00, 16'd6, 1));
        step("rst_b0",    mk_s(0, 2'b01, 2'b00, 16'h0090, 1), mk_e(1, 0, 1, 0, 8'h90, 2'b01, 16'd6, 1));
        step("rst_b1",    mk_s(0, 2'b01, 2'b00, 16'h0091, 1), mk_e(1, 0, 1, 0, 8'h91, 2'b01, 16'd6, 1));
        step("rst_pulse", mk_s(1, 2'b01, 2'b00, 16'h0092, 1), mk_e(1, 0, 1, 0, 8'h92, 2'b01, 16'd6, 1));
        step("rst_after", mk_s(0, 2'b10, 2'b00, 16'hA093, 1), mk_e(0, 0, 0, 0, 8'h00, 2'b00, 16'd0, 0));
        step("rst_src1",  mk_s(0, 2'b10, 2'b10, 16'hA000, 1), mk_e(1, 1, 1, 1, 8'hA0, 2'b10, 16'd0, 0));
        step("rst_done",  mk_s(0, 2'b00, 2'b00, 16'h0000, 1), mk_e(0, 1, 0, 0, 8'h00, 2'b00, 16'd1, 0));

        // Counter wrap: bring pkt_count near the top, then send one-beat packets
        // from a lone src0 which is re-granted back-to-back.
        @(negedge aclk);
        force dut.pkt_count_q = 16'hFFFE;
        @(negedge aclk);
        release dut.pkt_count_q;
        step("wrap_hold", mk_s(0, 2'b00, 2'b00, 16'h0000, 1), mk_e(0, 1, 0, 0, 8'h00, 2'b00, 16'hFFFE, 0));
        step("wrap_req0", mk_s(0, 2'b01, 2'b01, 16'h005A, 1), mk_e(0, 1, 0, 0, 8'h00, 2'b00, 16'hFFFE, 0));
        step("wrap_pkt0", mk_s(0, 2'b01, 2'b01, 16'h005A, 1), mk_e(1, 0, 1, 1, 8'h5A, 2'b01, 16'hFFFE, 0));
        step("wrap_req1", mk_s(0, 2'b01, 2'b01, 16'h005B, 1), mk_e(0, 0, 0, 0, 8'h00, 2'b00, 16'hFFFF, 0));
        step("wrap_pkt1", mk_s(0, 2'b01, 2'b01, 16'h005B, 1), mk_e(1, 0, 1, 1, 8'h5B, 2'b01, 16'hFFFF, 0));
        step("wrap_zero", mk_s(0, 2'b00, 2'b00, 16'h0000, 1), mk_e(0, 0, 0, 0, 8'h00, 2'b00, 16'h0000, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi4stream_packet_arbiter.md
AXI4STREAM_PACKET_ARBITER -- requirements
Module: axi4stream_packet_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 2, meaning number of AXI4-Stream sources (2..4).
REQ-002 The block SHALL have parameter AXI_WIDTH, default 8, meaning tdata width per beat.
REQ-003 The block SHALL have parameter MAX_BEATS, default 8, meaning maximum beats per packet before forced termination (>=2).
REQ-004 aclk  input  1  clock; one clock domain; all logic on rising edge.
REQ-005 areset  input  1  reset, synchronous and active-high.
REQ-006 s_tdata  input  NUM_SRC*AXI_WIDTH  source data; source i at bits [i*AXI_WIDTH +: AXI_WIDTH].
REQ-007 s_tvalid  input  NUM_SRC  per-source valid.
REQ-008 s_tlast  input  NUM_SRC  per-source end of packet.
REQ-009 s_tready  output  NUM_SRC  per-source ready.
REQ-010 m_tdata  output  AXI_WIDTH  data to axi4stream_input_buffer.
REQ-011 m_tvalid, m_tlast  output  1 each  master valid and end of packet.
REQ-012 m_tready  input  1  ready from the input buffer.
REQ-013 grant_id  output  clog2(NUM_SRC), minimum 1  index of the granted source.
REQ-014 busy  output  1  high while in GRANT.
REQ-015 pkt_count  output  16  completed packets, wraps 0xFFFF->0x0000.
REQ-016 err_overlong  output  1  sticky; set on forced termination.

Function
REQ-017 The FSM SHALL have two states: IDLE and GRANT.
REQ-018 In IDLE, all s_tready, m_tvalid and m_tlast SHALL be 0, and busy SHALL be 0.
REQ-019 In IDLE with any s_tvalid high, the FSM SHALL select the first requesting source, searching round-robin from last_grant+1 modulo NUM_SRC; it SHALL register that source into grant_id and enter GRANT on the next edge (1-cycle arbitration latency).
REQ-020 In GRANT, the path SHALL be combinational pass-through: m_tdata=s_tdata[g], m_tvalid=s_tvalid[g], s_tready[g]=m_tready, and s_tready of non-granted sources SHALL be 0.
REQ-021 A beat SHALL transfer only when m_tvalid and m_tready are both high; beat_cnt SHALL increment per beat and clear on packet end.
REQ-022 m_tlast SHALL equal s_tlast[g] OR (beat_cnt==MAX_BEATS-1).
REQ-023 On a beat with m_tlast high, the FSM SHALL return to IDLE next cycle, set last_grant=g, and increment pkt_count.
REQ-024 If that final beat had s_tlast[g]=0, err_overlong SHALL be set, the packet end SHALL be forced, and the remaining source beats SHALL be treated as a new packet.
REQ-025 grant_id SHALL hold its value in IDLE; the grant SHALL NOT change mid-packet regardless of other requests.
REQ-026 When s_tvalid[g] drops mid-packet, GRANT SHALL be held and m_tvalid SHALL be 0; no timeout applies.
REQ-027 Requests that arrive in the same cycle SHALL be resolved strictly by round-robin order; a lone requester SHALL be re-granted back-to-back, with one IDLE cycle between packets.

Reset
REQ-028 On areset, the FSM SHALL go to IDLE, grant_id=0, last_grant=NUM_SRC-1 (so source 0 wins first), beat_cnt=0, pkt_count=0, err_overlong=0, and all outputs SHALL be 0.
REQ-029 On areset mid-packet, the packet SHALL be abandoned with no pkt_count increment; the source is responsible for restarting it.
REQ-030 areset SHALL take priority over every other event in the same cycle.

Structure
REQ-031 The FSM state encoding and the rr_next function/constants SHALL be placed in shared package video_axis_pkg.
REQ-032 The round-robin selector SHALL be one sub-module, rr_arbiter (request vector and last_grant in, one-hot plus index out).
REQ-033 The datapath SHALL contain no data storage; only the FSM, counters and grant registers are sequential.

Verification
REQ-034 Src0 sends AA,BB,CC,DD with tlast on DD, m_tready=1 -> busy 1 cycle after request; m_tdata AA..DD on 4 consecutive cycles; pkt_count=1; grant_id=0.
REQ-035 Src0 and src1 both valid from reset; src1 sends EF,BE,AD,DE -> src0 packet first, one IDLE cycle, then src1 packet; pkt_count=2; s_tready[1]=0 throughout src0's packet.
REQ-036 Src0 streams 21,43,65,87 repeatedly with no tlast, MAX_BEATS=8 -> m_tlast on 8th beat; err_overlong=1; IDLE cycle; src0 re-granted.
REQ-037 m_tready toggles 1,0,1,0 during src1 packet -> no beat lost or duplicated; s_tready[1] mirrors m_tready.
REQ-038 areset pulsed after 2 beats of src0 -> next cycle all outputs 0, pkt_count=0; after release, src1 alone requesting is granted.
REQ-039 pkt_count preloaded to 0xFFFF via 65535 one-beat packets -> next packet wraps pkt_count to 0x0000.
